e2prom_arb: RTL and testbench

Two-port arbiter for the board's single EEPROM controller. It replaces the wire-OR of the scan-side requester (port 0, datas_scan_DO) and the download requester (port 1, down_IO) inside console_DO. One transaction runs at a time, with round-robin grant and a watchdog that cleans up if the controller hangs. Each requester gets its command accepted, its write stream forwarded, its read stream routed back, and a done/err pulse at completion.

---
 rtl/e2prom_arb_pkg.sv | 20 ++
 rtl/e2prom_arb_wdog.sv | 31 +++
 rtl/e2prom_arb.sv | 249 ++++++++++++++++++++++++
 tb/tb_e2prom_arb.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e2prom_arb_pkg.sv
// e2prom_arb shared types and constants.
// Port indices, field widths and FSM state encoding.
package e2prom_arb_pkg;

  localparam int ADDR_W = 17;
  localparam int LEN_W  = 17;

  localparam logic P_SCAN = 1'b0;
  localparam logic P_DOWN = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WDATA,
    S_RDATA,
    S_WAIT_RDY,
    S_DONE
  } state_t;

endpackage

// File: rtl/e2prom_arb_wdog.sv
// Transaction watchdog: counts while enabled, expires on the
// cycle that would complete TO_CYC cycles since the count began.
module e2prom_arb_wdog #(
  parameter int              TO_W   = 24,
  parameter logic [TO_W-1:0] TO_CYC = 24'd1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [TO_W-1:0] LIM =
    TO_CYC - {{(TO_W-1){1'b0}}, 1'b1};

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt == LIM);

endmodule

// File: rtl/e2prom_arb.sv
// Two-port round-robin arbiter in front of the EEPROM controller.
// One transaction at a time; watchdog forces completion on a hang.
module e2prom_arb
  import e2prom_arb_pkg::*;
#(
  parameter int              TO_W   = 24,
  parameter logic [TO_W-1:0] TO_CYC = 24'd1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i0_req,
  input  logic              i0_wr,
  input  logic [ADDR_W-1:0] im0_addr,
  input  logic [LEN_W-1:0]  im0_len,
  input  logic [7:0]        im0_wdata,
  input  logic              i0_wr_dv,
  input  logic              i0_wr_last,
  input  logic              i1_req,
  input  logic              i1_wr,
  input  logic [ADDR_W-1:0] im1_addr,
  input  logic [LEN_W-1:0]  im1_len,
  input  logic [7:0]        im1_wdata,
  input  logic              i1_wr_dv,
  input  logic              i1_wr_last,
  output logic              o0_gnt,
  output logic [7:0]        om0_rdata,
  output logic              o0_rd_dv,
  output logic              o0_rd_last,
  output logic              o0_done,
  output logic              o0_err,
  output logic              o1_gnt,
  output logic [7:0]        om1_rdata,
  output logic              o1_rd_dv,
  output logic              o1_rd_last,
  output logic              o1_done,
  output logic              o1_err,
  output logic              o_e2prom_rden,
  output logic              o_e2prom_wren,
  output logic [ADDR_W-1:0] om_e2prom_addr,
  output logic [LEN_W-1:0]  om_e2prom_wr_len,
  output logic [7:0]        om_e2prom_wdata,
  output logic              o_e2prom_wr_dv,
  output logic              o_e2prom_wr_last,
  input  logic              i_e2prom_ready,
  input  logic [7:0]        im_e2prom_rd_data,
  input  logic              i_e2prom_rd_valid,
  input  logic              i_e2prom_rd_last
);

  state_t r_state, w_next;

  logic              r_gnt, r_port, r_last, r_wr, r_busy;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic              r_rden, r_wren;
  logic [7:0]        r_wdata, r_rd_data;
  logic              r_wr_dv, r_wr_last;
  logic              r_rd_dv, r_rd_last;
  logic              r_done, r_err;

  logic              w_gnt_d, w_port_d, w_last_d, w_wr_d, w_busy_d;
  logic [ADDR_W-1:0] w_addr_d;
  logic [LEN_W-1:0]  w_len_d;
  logic              w_rden_d, w_wren_d;
  logic [7:0]        w_wdata_d, w_rd_data_d;
  logic              w_wr_dv_d, w_wr_last_d;
  logic              w_rd_dv_d, w_rd_last_d;
  logic              w_done_d, w_err_d;

  logic              w_pick, w_c_wr, w_g_dv, w_g_last;
  logic [ADDR_W-1:0] w_c_addr;
  logic [LEN_W-1:0]  w_c_len;
  logic [7:0]        w_g_wdata;
  logic              w_expire, w_wd_en, w_wd_clr;
  logic              w_is0, w_is1;

  // On a tie the port not served last wins.
  assign w_pick   = (i0_req && i1_req) ? ~r_last : i1_req;
  assign w_c_wr   = w_pick ? i1_wr    : i0_wr;
  assign w_c_addr = w_pick ? im1_addr : im0_addr;
  assign w_c_len  = w_pick ? im1_len  : im0_len;

  assign w_g_wdata = r_port ? im1_wdata  : im0_wdata;
  assign w_g_dv    = r_port ? i1_wr_dv   : i0_wr_dv;
  assign w_g_last  = r_port ? i1_wr_last : i0_wr_last;

  assign w_wd_clr = (r_state == S_IDLE);
  assign w_wd_en  = (r_state != S_IDLE) && (r_state != S_DONE);

  e2prom_arb_wdog #(
    .TO_W   (TO_W),
    .TO_CYC (TO_CYC)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .o_expire (w_expire)
  );

  always_comb begin
    w_next      = r_state;
    w_gnt_d     = r_gnt;
    w_port_d    = r_port;
    w_last_d    = r_last;
    w_wr_d      = r_wr;
    w_addr_d    = r_addr;
    w_len_d     = r_len;
    w_busy_d    = r_busy;
    w_rden_d    = 1'b0;
    w_wren_d    = 1'b0;
    w_wdata_d   = '0;
    w_wr_dv_d   = 1'b0;
    w_wr_last_d = 1'b0;
    w_rd_data_d = '0;
    w_rd_dv_d   = 1'b0;
    w_rd_last_d = 1'b0;
    w_done_d    = 1'b0;
    w_err_d     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_e2prom_ready && (i0_req || i1_req)) begin
          w_next   = S_ISSUE;
          w_gnt_d  = 1'b1;
          w_port_d = w_pick;
          w_wr_d   = w_c_wr;
          w_addr_d = w_c_addr;
          w_len_d  = (w_c_len == '0) ?
                     {{(LEN_W-1){1'b0}}, 1'b1} : w_c_len;
          w_rden_d = ~w_c_wr;
          w_wren_d = w_c_wr;
        end
      end
      S_ISSUE: begin
        w_busy_d = 1'b0;
        w_next   = r_wr ? S_WDATA : S_RDATA;
      end
      S_WDATA: begin
        w_busy_d    = r_busy | ~i_e2prom_ready;
        w_wdata_d   = w_g_wdata;
        w_wr_dv_d   = w_g_dv;
        w_wr_last_d = w_g_dv & w_g_last;
        if (w_g_dv && w_g_last) w_next = S_WAIT_RDY;
      end
      S_RDATA: begin
        w_busy_d    = r_busy | ~i_e2prom_ready;
        w_rd_data_d = im_e2prom_rd_data;
        w_rd_dv_d   = i_e2prom_rd_valid;
        w_rd_last_d = i_e2prom_rd_valid & i_e2prom_rd_last;
        if (i_e2prom_rd_valid && i_e2prom_rd_last)
          w_next = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        w_busy_d = r_busy | ~i_e2prom_ready;
        if (r_busy && i_e2prom_ready) begin
          w_next   = S_DONE;
          w_done_d = 1'b1;
        end
      end
      S_DONE: begin
        w_gnt_d  = 1'b0;
        w_last_d = r_port;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_expire) begin
      w_next      = S_DONE;
      w_done_d    = 1'b1;
      w_err_d     = 1'b1;
      w_rden_d    = 1'b0;
      w_wren_d    = 1'b0;
      w_wdata_d   = '0;
      w_wr_dv_d   = 1'b0;
      w_wr_last_d = 1'b0;
      w_rd_data_d = '0;
      w_rd_dv_d   = 1'b0;
      w_rd_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_gnt     <= 1'b0;
      r_port    <= P_SCAN;
      r_last    <= P_SCAN;
      r_wr      <= 1'b0;
      r_busy    <= 1'b0;
      r_addr    <= '0;
      r_len     <= '0;
      r_rden    <= 1'b0;
      r_wren    <= 1'b0;
      r_wdata   <= '0;
      r_wr_dv   <= 1'b0;
      r_wr_last <= 1'b0;
      r_rd_data <= '0;
      r_rd_dv   <= 1'b0;
      r_rd_last <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_gnt     <= w_gnt_d;
      r_port    <= w_port_d;
      r_last    <= w_last_d;
      r_wr      <= w_wr_d;
      r_busy    <= w_busy_d;
      r_addr    <= w_addr_d;
      r_len     <= w_len_d;
      r_rden    <= w_rden_d;
      r_wren    <= w_wren_d;
      r_wdata   <= w_wdata_d;
      r_wr_dv   <= w_wr_dv_d;
      r_wr_last <= w_wr_last_d;
      r_rd_data <= w_rd_data_d;
      r_rd_dv   <= w_rd_dv_d;
      r_rd_last <= w_rd_last_d;
      r_done    <= w_done_d;
      r_err     <= w_err_d;
    end
  end

  assign w_is0 = (r_port == P_SCAN);
  assign w_is1 = (r_port == P_DOWN);

  assign o0_gnt     = r_gnt & w_is0;
  assign om0_rdata  = w_is0 ? r_rd_data : '0;
  assign o0_rd_dv   = r_rd_dv & w_is0;
  assign o0_rd_last = r_rd_last & w_is0;
  assign o0_done    = r_done & w_is0;
  assign o0_err     = r_err & w_is0;

  assign o1_gnt     = r_gnt & w_is1;
  assign om1_rdata  = w_is1 ? r_rd_data : '0;
  assign o1_rd_dv   = r_rd_dv & w_is1;
  assign o1_rd_last = r_rd_last & w_is1;
  assign o1_done    = r_done & w_is1;
  assign o1_err     = r_err & w_is1;

  assign o_e2prom_rden    = r_rden;
  assign o_e2prom_wren    = r_wren;
  assign om_e2prom_addr   = r_addr;
  assign om_e2prom_wr_len = r_len;
  assign om_e2prom_wdata  = r_wdata;
  assign o_e2prom_wr_dv   = r_wr_dv;
  assign o_e2prom_wr_last = r_wr_last;

endmodule

// File: tb/tb_e2prom_arb.sv
// Directed bench for e2prom_arb: read, write, tie-break,
// watchdog abort and reset mid-transaction.
module tb_e2prom_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i0_req = 0, i0_wr = 0, i0_wr_dv = 0, i0_wr_last = 0;
  logic [16:0] im0_addr = '0, im0_len = '0;
  logic [7:0]  im0_wdata = '0;
  logic        i1_req = 0, i1_wr = 0, i1_wr_dv = 0, i1_wr_last = 0;
  logic [16:0] im1_addr = '0, im1_len = '0;
  logic [7:0]  im1_wdata = '0;
  logic        o0_gnt, o0_rd_dv, o0_rd_last, o0_done, o0_err;
  logic        o1_gnt, o1_rd_dv, o1_rd_last, o1_done, o1_err;
  logic [7:0]  om0_rdata, om1_rdata;
  logic        o_e2prom_rden, o_e2prom_wren;
  logic [16:0] om_e2prom_addr, om_e2prom_wr_len;
  logic [7:0]  om_e2prom_wdata;
  logic        o_e2prom_wr_dv, o_e2prom_wr_last;
  logic        i_e2prom_ready = 1'b1;
  logic [7:0]  im_e2prom_rd_data = '0;
  logic        i_e2prom_rd_valid = 1'b0, i_e2prom_rd_last = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  e2prom_arb #(.TO_W(24), .TO_CYC(24'd50)) dut (
    .clk(clk), .rst(rst),
    .i0_req(i0_req), .i0_wr(i0_wr), .im0_addr(im0_addr),
    .im0_len(im0_len), .im0_wdata(im0_wdata),
    .i0_wr_dv(i0_wr_dv), .i0_wr_last(i0_wr_last),
    .i1_req(i1_req), .i1_wr(i1_wr), .im1_addr(im1_addr),
    .im1_len(im1_len), .im1_wdata(im1_wdata),
    .i1_wr_dv(i1_wr_dv), .i1_wr_last(i1_wr_last),
    .o0_gnt(o0_gnt), .om0_rdata(om0_rdata), .o0_rd_dv(o0_rd_dv),
    .o0_rd_last(o0_rd_last), .o0_done(o0_done), .o0_err(o0_err),
    .o1_gnt(o1_gnt), .om1_rdata(om1_rdata), .o1_rd_dv(o1_rd_dv),
    .o1_rd_last(o1_rd_last), .o1_done(o1_done), .o1_err(o1_err),
    .o_e2prom_rden(o_e2prom_rden), .o_e2prom_wren(o_e2prom_wren),
    .om_e2prom_addr(om_e2prom_addr),
    .om_e2prom_wr_len(om_e2prom_wr_len),
    .om_e2prom_wdata(om_e2prom_wdata),
    .o_e2prom_wr_dv(o_e2prom_wr_dv),
    .o_e2prom_wr_last(o_e2prom_wr_last),
    .i_e2prom_ready(i_e2prom_ready),
    .im_e2prom_rd_data(im_e2prom_rd_data),
    .i_e2prom_rd_valid(i_e2prom_rd_valid),
    .i_e2prom_rd_last(i_e2prom_rd_last)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Drives a one-byte read from the ISSUE cycle through to DONE.
  task automatic serve_read;
    i_e2prom_ready = 1'b0;
    tick();
    im_e2prom_rd_data = 8'h5A;
    i_e2prom_rd_valid = 1'b1;
    i_e2prom_rd_last = 1'b1;
    tick();
    i_e2prom_rd_valid = 1'b0;
    i_e2prom_rd_last = 1'b0;
    i_e2prom_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    logic [11:0] v;
    rst = 1'b0;
    tick();
    tick();
    v = {o0_gnt, o1_gnt, o_e2prom_rden, o_e2prom_wren,
         o_e2prom_wr_dv, o_e2prom_wr_last, o0_rd_dv, o1_rd_dv,
         o0_done, o1_done, o0_err, o1_err};
    checks++;
    if (v !== 12'h000) begin
      failures++;
      $display("FAIL reset_ctrl got=%h exp=000", v);
    end
    checks++;
    if ({om_e2prom_addr, om_e2prom_wr_len, om_e2prom_wdata,
         om0_rdata, om1_rdata} !== 58'h0) begin
      failures++;
      $display("FAIL reset_data got addr=%h len=%h exp=0",
               om_e2prom_addr, om_e2prom_wr_len);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_read_p0;
    logic [7:0] b [4];
    logic       lst;
    int         nd;
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    nd = 0;
    i0_req = 1'b1; i0_wr = 1'b0;
    im0_addr = 17'h00100; im0_len = 17'd4;
    i_e2prom_ready = 1'b1;
    tick();
    checks++;
    if ({o_e2prom_rden, o_e2prom_wren, o0_gnt, o1_gnt} !== 4'b1010) begin
      failures++;
      $display("FAIL rd_strobe got=%b exp=1010",
               {o_e2prom_rden, o_e2prom_wren, o0_gnt, o1_gnt});
    end
    checks++;
    if (om_e2prom_addr !== 17'h00100 || om_e2prom_wr_len !== 17'd4) begin
      failures++;
      $display("FAIL rd_cmd got=%h/%h exp=00100/00004",
               om_e2prom_addr, om_e2prom_wr_len);
    end
    i_e2prom_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      lst = (i == 3);
      im_e2prom_rd_data = b[i];
      i_e2prom_rd_valid = 1'b1;
      i_e2prom_rd_last = lst;
      tick();
      nd += int'(o0_done);
      checks++;
      if ({o0_rd_dv, o0_rd_last, om0_rdata} !== {1'b1, lst, b[i]}) begin
        failures++;
        $display("FAIL rd_byte%0d got=%b/%b/%h exp=1/%b/%h", i,
                 o0_rd_dv, o0_rd_last, om0_rdata, lst, b[i]);
      end
      checks++;
      if ({o1_rd_dv, o1_rd_last, om1_rdata} !== 10'h0) begin
        failures++;
        $display("FAIL rd_p1_quiet%0d got=%b/%h exp=0/00", i,
                 o1_rd_dv, om1_rdata);
      end
    end
    i_e2prom_rd_valid = 1'b0;
    i_e2prom_rd_last = 1'b0;
    im_e2prom_rd_data = '0;
    i_e2prom_ready = 1'b1;
    tick();
    nd += int'(o0_done);
    checks++;
    if ({o0_done, o0_err, o1_done} !== 3'b100) begin
      failures++;
      $display("FAIL rd_done got=%b exp=100", {o0_done, o0_err, o1_done});
    end
    i0_req = 1'b0;
    repeat (3) begin
      tick();
      nd += int'(o0_done);
    end
    checks++;
    if (nd !== 1 || o0_gnt !== 1'b0) begin
      failures++;
      $display("FAIL rd_once got=%0d gnt=%b exp=1 gnt=0", nd, o0_gnt);
    end
  endtask

  task automatic test_write_p1;
    logic [7:0] b [3];
    logic       lst;
    int         nw;
    b = '{8'h11, 8'h22, 8'h33};
    i1_req = 1'b1; i1_wr = 1'b1;
    im1_addr = 17'h1FFFF; im1_len = 17'd3;
    i_e2prom_ready = 1'b1;
    tick();
    nw = int'(o_e2prom_wren);
    checks++;
    if ({o_e2prom_rden, o_e2prom_wren, o0_gnt, o1_gnt} !== 4'b0101 ||
        om_e2prom_addr !== 17'h1FFFF || om_e2prom_wr_len !== 17'd3) begin
      failures++;
      $display("FAIL wr_strobe got=%b %h/%h exp=0101 1ffff/00003",
               {o_e2prom_rden, o_e2prom_wren, o0_gnt, o1_gnt},
               om_e2prom_addr, om_e2prom_wr_len);
    end
    tick();
    nw += int'(o_e2prom_wren);
    i_e2prom_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lst = (i == 2);
      im1_wdata = b[i];
      i1_wr_dv = 1'b1;
      i1_wr_last = lst;
      im0_wdata = 8'h99;
      i0_wr_dv = 1'b1;
      tick();
      nw += int'(o_e2prom_wren);
      checks++;
      if ({o_e2prom_wr_dv, o_e2prom_wr_last, om_e2prom_wdata} !==
          {1'b1, lst, b[i]}) begin
        failures++;
        $display("FAIL wr_byte%0d got=%b/%b/%h exp=1/%b/%h", i,
                 o_e2prom_wr_dv, o_e2prom_wr_last, om_e2prom_wdata,
                 lst, b[i]);
      end
    end
    i1_wr_dv = 1'b0; i1_wr_last = 1'b0;
    repeat (7) begin
      tick();
      nw += int'(o_e2prom_wren);
      checks++;
      if ({o1_done, o_e2prom_wr_dv} !== 2'b00) begin
        failures++;
        $display("FAIL wr_busy got=%b exp=00", {o1_done, o_e2prom_wr_dv});
      end
    end
    i0_wr_dv = 1'b0;
    i_e2prom_ready = 1'b1;
    tick();
    checks++;
    if ({o1_done, o1_err, o0_done} !== 3'b100) begin
      failures++;
      $display("FAIL wr_done got=%b exp=100", {o1_done, o1_err, o0_done});
    end
    checks++;
    if (nw !== 1) begin
      failures++;
      $display("FAIL wr_wren_once got=%0d exp=1", nw);
    end
    i1_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_tie;
    do_reset();
    i0_wr = 1'b0; i1_wr = 1'b0;
    im0_addr = 17'h00010; im1_addr = 17'h00020;
    im0_len = 17'd1; im1_len = 17'd1;
    for (int r = 0; r < 2; r++) begin
      i0_req = 1'b1; i1_req = 1'b1;
      tick();
      checks++;
      if ({o0_gnt, o1_gnt} !== 2'b01) begin
        failures++;
        $display("FAIL tie%0d_first got=%b exp=01", r, {o0_gnt, o1_gnt});
      end
      serve_read();
      checks++;
      if ({o0_done, o1_done} !== 2'b01) begin
        failures++;
        $display("FAIL tie%0d_done1 got=%b exp=01", r, {o0_done, o1_done});
      end
      i1_req = 1'b0;
      tick();
      tick();
      checks++;
      if ({o0_gnt, o1_gnt, o_e2prom_rden} !== 3'b101) begin
        failures++;
        $display("FAIL tie%0d_second got=%b exp=101", r,
                 {o0_gnt, o1_gnt, o_e2prom_rden});
      end
      serve_read();
      checks++;
      if ({o0_done, o1_done} !== 2'b10) begin
        failures++;
        $display("FAIL tie%0d_done0 got=%b exp=10", r, {o0_done, o1_done});
      end
      i0_req = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic test_watchdog;
    int nd;
    do_reset();
    i0_req = 1'b1; i0_wr = 1'b0;
    im0_addr = 17'h00040; im0_len = 17'd8;
    i_e2prom_ready = 1'b1;
    tick();
    checks++;
    if (o_e2prom_rden !== 1'b1) begin
      failures++;
      $display("FAIL wd_strobe got=%b exp=1", o_e2prom_rden);
    end
    i_e2prom_ready = 1'b0;
    nd = 0;
    repeat (49) begin
      tick();
      nd += int'(o0_done);
    end
    checks++;
    if (nd !== 0) begin
      failures++;
      $display("FAIL wd_early got=%0d exp=0", nd);
    end
    tick();
    checks++;
    if ({o0_done, o0_err} !== 2'b11) begin
      failures++;
      $display("FAIL wd_abort got=%b exp=11", {o0_done, o0_err});
    end
    checks++;
    if ({o_e2prom_rden, o_e2prom_wren, o_e2prom_wr_dv, o0_rd_dv} !==
        4'b0000) begin
      failures++;
      $display("FAIL wd_quiet got=%b exp=0000",
               {o_e2prom_rden, o_e2prom_wren, o_e2prom_wr_dv, o0_rd_dv});
    end
    i0_req = 1'b0;
    i_e2prom_ready = 1'b1;
    tick();
    checks++;
    if ({o0_gnt, o0_done, o0_err} !== 3'b000) begin
      failures++;
      $display("FAIL wd_idle got=%b exp=000", {o0_gnt, o0_done, o0_err});
    end
    tick();
  endtask

  task automatic test_reset_mid_write;
    int nd;
    do_reset();
    i0_req = 1'b1; i0_wr = 1'b1;
    im0_addr = 17'h00005; im0_len = 17'd0;
    i_e2prom_ready = 1'b1;
    tick();
    checks++;
    if (o_e2prom_wren !== 1'b1 || om_e2prom_wr_len !== 17'd1) begin
      failures++;
      $display("FAIL len0 got=%b/%h exp=1/00001",
               o_e2prom_wren, om_e2prom_wr_len);
    end
    tick();
    im0_wdata = 8'hA1; i0_wr_dv = 1'b1;
    tick();
    im0_wdata = 8'hA2;
    tick();
    checks++;
    if ({o_e2prom_wr_dv, om_e2prom_wdata} !== {1'b1, 8'hA2}) begin
      failures++;
      $display("FAIL mw_byte got=%b/%h exp=1/a2",
               o_e2prom_wr_dv, om_e2prom_wdata);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({o0_gnt, o_e2prom_wr_dv, om_e2prom_wdata, o_e2prom_wren,
         o0_done, o0_err} !== 13'h0) begin
      failures++;
      $display("FAIL mw_async got gnt=%b dv=%b d=%h exp=0",
               o0_gnt, o_e2prom_wr_dv, om_e2prom_wdata);
    end
    i0_req = 1'b0; i0_wr_dv = 1'b0;
    nd = 0;
    repeat (2) begin
      tick();
      nd += int'(o0_done);
    end
    rst = 1'b1;
    tick();
    nd += int'(o0_done);
    checks++;
    if (nd !== 0) begin
      failures++;
      $display("FAIL mw_nodone got=%0d exp=0", nd);
    end
    i0_req = 1'b1; i0_wr = 1'b0;
    im0_addr = 17'h00020; im0_len = 17'd1;
    tick();
    checks++;
    if ({o0_gnt, o_e2prom_rden, om_e2prom_addr} !==
        {1'b1, 1'b1, 17'h00020}) begin
      failures++;
      $display("FAIL mw_regrant got=%b/%b/%h exp=1/1/00020",
               o0_gnt, o_e2prom_rden, om_e2prom_addr);
    end
    serve_read();
    checks++;
    if ({o0_done, o0_err} !== 2'b10) begin
      failures++;
      $display("FAIL mw_read_done got=%b exp=10", {o0_done, o0_err});
    end
    i0_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read_p0();
    test_write_p1();
    test_tie();
    test_watchdog();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
